// File: rtl/mul_add_pkg.sv
// ---------------------------------------------------------------------------
// mul_add_pkg
//
// Shared constants and width helpers for the pipelined multiply-add unit.
//
// Contents:
//   MUL_ADD_N_DEFAULT  default operand width (bits)
//   MUL_ADD_N_MIN/MAX  legal operand width range
//   MUL_ADD_LAT        pipeline latency in enabled edges for the default width
//   w2(n)              accumulator / result width for operand width n
//   mul_add_lat(n)     latency in enabled edges for operand width n
//
// The latency equals the operand width because one multiplier bit is
// resolved per stage. Benches use MUL_ADD_LAT to align a reference stream
// with the pipeline output.
// ---------------------------------------------------------------------------
package mul_add_pkg;

  localparam int MUL_ADD_N_DEFAULT = 32;
  localparam int MUL_ADD_N_MIN     = 2;
  localparam int MUL_ADD_N_MAX     = 64;

  // One stage per multiplier bit, so latency tracks the operand width.
  localparam int MUL_ADD_LAT       = MUL_ADD_N_DEFAULT;

  // The maximum result (2^N-1)^2 + (2^N-1) = 2^2N - 2^N fits in 2N bits,
  // so the accumulator needs no carry-out bit.
  function automatic int w2(input int n);
    return 2 * n;
  endfunction

  function automatic int mul_add_lat(input int n);
    return n;
  endfunction

endpackage : mul_add_pkg

// File: rtl/mul_add_stage.sv
// ---------------------------------------------------------------------------
// mul_add_stage
//
// One shift-add step of the pipelined multiply-add unit. It conditionally
// adds the pre-shifted multiplicand into the partial sum, depending on the
// lowest remaining multiplier bit, and registers the result together with
// the multiplicand shifted left by one and the multiplier shifted right by
// one.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous reset, active low (clears every register)
//   en_i    in   advance; 0 holds all registers
//   v_i     in   valid bit from the previous stage (or the load)
//   acc_i   in   partial sum, 2N bits
//   mc_i    in   multiplicand, pre-shifted, 2N bits
//   mp_i    in   remaining multiplier bits, N bits (bit 0 is used here)
//   v_o     out  registered valid bit
//   acc_o   out  registered partial sum
//   mc_o    out  registered multiplicand, shifted left by one
//   mp_o    out  registered multiplier, shifted right by one
//
// Data moves regardless of v_i; the valid bit only marks which slots
// carry real operations.
// ---------------------------------------------------------------------------
module mul_add_stage
  import mul_add_pkg::*;
#(
  parameter  int N  = MUL_ADD_N_DEFAULT,
  localparam int W2 = 2 * N
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          v_i,
  input  logic [W2-1:0] acc_i,
  input  logic [W2-1:0] mc_i,
  input  logic [N-1:0]  mp_i,
  output logic          v_o,
  output logic [W2-1:0] acc_o,
  output logic [W2-1:0] mc_o,
  output logic [N-1:0]  mp_o
);

  logic          v_q,   v_d;
  logic [W2-1:0] acc_q, acc_d;
  logic [W2-1:0] mc_q,  mc_d;
  logic [N-1:0]  mp_q,  mp_d;

  // Shift-add step. The sum cannot overflow 2N bits for any legal
  // operands, so the carry-out is simply dropped.
  always_comb begin
    v_d   = v_i;
    acc_d = acc_i;
    if (mp_i[0]) begin
      acc_d = acc_i + mc_i;
    end
    mc_d  = mc_i << 1;
    mp_d  = mp_i >> 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= 1'b0;
      acc_q <= '0;
      mc_q  <= '0;
      mp_q  <= '0;
    end else if (en_i) begin
      v_q   <= v_d;
      acc_q <= acc_d;
      mc_q  <= mc_d;
      mp_q  <= mp_d;
    end
  end

  assign v_o   = v_q;
  assign acc_o = acc_q;
  assign mc_o  = mc_q;
  assign mp_o  = mp_q;

endmodule : mul_add_stage

// File: rtl/mul_add.sv
// ---------------------------------------------------------------------------
// mul_add
//
// Pipelined unsigned multiply-add: product = a*b + c, one operation per
// enabled clock, fixed latency of N enabled edges. Feeding it a divider's
// (quotient, divisor, remainder) rebuilds the original dividend.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low; discards in-flight work
//   en         in   pipeline advance; 0 freezes every register and ignores
//                   the inputs for that cycle (a valid operand is dropped)
//   in_valid   in   a/b/c carry a real operation this cycle
//   a          in   multiplicand, N bits, unsigned
//   b          in   multiplier, N bits, unsigned
//   c          in   addend, N bits, unsigned
//   out_valid  out  product holds a completed result
//   product    out  a*b + c, 2N bits, registered
//
// Handshake: there is no ready/backpressure. An operation is accepted on
// a rising edge where en=1 and in_valid=1; its result is presented with
// out_valid=1 after the N-th enabled edge counting the accepting edge.
// Upstream is responsible for qualifying in_valid with en.
//
// Structure: the S0 load is formed combinationally here ({0,c}, {0,a}, b)
// and fed into the first of N identical shift-add stages. Folding the
// bit-0 add into the first stage register keeps the latency at exactly N.
// Stage k handles multiplier bit k. The valid bits form a shift chain
// alongside the data; bubbles carry don't-care data with v=0.
// ---------------------------------------------------------------------------
module mul_add
  import mul_add_pkg::*;
#(
  parameter int N = MUL_ADD_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_valid,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [N-1:0]   c,
  output logic           out_valid,
  output logic [2*N-1:0] product
);

  localparam int W2 = w2(N);

  // Index k is the input of stage k; index N is the output of the last
  // stage.
  logic [N:0]           v_s;
  logic [N:0][W2-1:0]   acc_s;
  logic [N:0][W2-1:0]   mc_s;
  logic [N:0][N-1:0]    mp_s;

  // S0 load: addend seeds the accumulator, multiplicand zero-extended.
  assign v_s[0]   = in_valid;
  assign acc_s[0] = {{N{1'b0}}, c};
  assign mc_s[0]  = {{N{1'b0}}, a};
  assign mp_s[0]  = b;

  for (genvar k = 0; k < N; k++) begin : g_stage
    mul_add_stage #(
      .N (N)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (en),
      .v_i   (v_s[k]),
      .acc_i (acc_s[k]),
      .mc_i  (mc_s[k]),
      .mp_i  (mp_s[k]),
      .v_o   (v_s[k+1]),
      .acc_o (acc_s[k+1]),
      .mc_o  (mc_s[k+1]),
      .mp_o  (mp_s[k+1])
    );
  end

  // The last stage's shifted multiplicand and exhausted multiplier are
  // not needed by anything downstream.
  logic unused_tail;
  assign unused_tail = ^{mc_s[N], mp_s[N]};

  assign out_valid = v_s[N];
  assign product   = acc_s[N];

endmodule : mul_add

// File: tb/tb_mul_add.sv
// ---------------------------------------------------------------------------
// tb_mul_add
//
// Self-checking bench for mul_add (N=32). A reference model keeps a queue
// of expected results, each tagged with the enabled-edge index at which it
// must appear on the output (accepting edge + latency - 1). Each scenario
// task drives one cycle at a time through drive_cycle, which advances the
// model, and then compares the DUT against the model inline.
// ---------------------------------------------------------------------------
module tb_mul_add;
  import mul_add_pkg::*;

  localparam int N   = 32;
  localparam int LAT = MUL_ADD_LAT;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           in_valid;
  logic [N-1:0]   a, b, c;
  logic           out_valid;
  logic [2*N-1:0] product;

  always #5 clk = ~clk;

  mul_add #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .product   (product)
  );

  // ---------------- scoreboard / reference model ----------------
  int             checks   = 0;
  int             failures = 0;
  logic [2*N-1:0] exp_q[$];
  int             due_q[$];
  int             edge_idx = 0;
  logic           exp_v;
  logic [2*N-1:0] exp_p;
  logic           exp_known;   // product value is defined (reset or a result)

  function automatic logic [2*N-1:0] golden(input logic [N-1:0] x, y, z);
    logic [2*N-1:0] xe, ye, ze;
    xe = {{N{1'b0}}, x};
    ye = {{N{1'b0}}, y};
    ze = {{N{1'b0}}, z};
    return xe * ye + ze;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    due_q.delete();
    exp_v     = 1'b0;
    exp_p     = '0;
    exp_known = 1'b1;
  endtask

  // Drive one cycle at the falling edge, let the rising edge happen,
  // update the model, and return 1 time unit after the rising edge.
  task automatic drive_cycle(input logic rst_in, input logic en_in,
                             input logic iv_in, input logic [N-1:0] a_in,
                             input logic [N-1:0] b_in, input logic [N-1:0] c_in,
                             input logic [2*N-1:0] gold);
    @(negedge clk);
    rst_n    = rst_in;
    en       = en_in;
    in_valid = iv_in;
    a        = a_in;
    b        = b_in;
    c        = c_in;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (en_in) begin
      edge_idx++;
      if (iv_in) begin
        exp_q.push_back(gold);
        due_q.push_back(edge_idx + LAT - 1);
      end
      if (due_q.size() > 0 && due_q[0] == edge_idx) begin
        exp_v     = 1'b1;
        exp_p     = exp_q.pop_front();
        void'(due_q.pop_front());
        exp_known = 1'b1;
      end else begin
        exp_v     = 1'b0;
        exp_known = 1'b0;
      end
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [N-1:0] x, y, z;
    // Held in reset with valid random operands: nothing may come out.
    for (int i = 0; i < 6; i++) begin
      x = $urandom(); y = $urandom(); z = $urandom();
      drive_cycle(1'b0, 1'b1, 1'b1, x, y, z, golden(x, y, z));
      checks++;
      if (out_valid !== 1'b0 || product !== '0) begin
        failures++;
        $display("FAIL reset_hold out_valid=%0b product=%h required out_valid=0 product=0",
                 out_valid, product);
      end
    end
    // Release; first accepted op must surface exactly LAT edges later.
    for (int i = 0; i < LAT + 8; i++) begin
      logic iv;
      iv = (i < 4);
      x = $urandom(); y = $urandom(); z = $urandom();
      drive_cycle(1'b1, 1'b1, iv, x, y, z, golden(x, y, z));
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL reset_release out_valid got=%0b exp=%0b cycle=%0d", out_valid, exp_v, i);
      end
      if (exp_v) begin
        checks++;
        if (product !== exp_p) begin
          failures++;
          $display("FAIL reset_release product got=%h exp=%h", product, exp_p);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [N-1:0]   ta[3];
    logic [N-1:0]   tb_[3];
    logic [N-1:0]   tc[3];
    logic [2*N-1:0] tg[3];
    // Hand-computed results, independent of the model arithmetic.
    ta[0] = 32'd7;          tb_[0] = 32'd6;          tc[0] = 32'd5;          tg[0] = 64'd47;
    ta[1] = 32'd0;          tb_[1] = 32'hFFFF_FFFF;  tc[1] = 32'd9;          tg[1] = 64'd9;
    ta[2] = 32'hFFFF_FFFF;  tb_[2] = 32'hFFFF_FFFF;  tc[2] = 32'hFFFF_FFFF;  tg[2] = 64'hFFFF_FFFF_0000_0000;
    for (int i = 0; i < 3 * 3 + LAT + 2; i++) begin
      logic iv;
      int   j;
      iv = (i % 3 == 0) && (i < 9);
      j  = (i / 3) % 3;
      drive_cycle(1'b1, 1'b1, iv, ta[j], tb_[j], tc[j], tg[j]);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL basic out_valid got=%0b exp=%0b cycle=%0d", out_valid, exp_v, i);
      end
      if (exp_v) begin
        checks++;
        if (product !== exp_p) begin
          failures++;
          $display("FAIL basic product got=%h exp=%h", product, exp_p);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] x, y, z;
    int           seen;
    seen = 0;
    for (int i = 0; i < 100 + LAT + 2; i++) begin
      x = $urandom(); y = $urandom(); z = $urandom();
      if (i % 10 == 0) begin
        x = 32'hFFFF_FFFF;  // mix in boundary operands
      end
      drive_cycle(1'b1, 1'b1, (i < 100), x, y, z, golden(x, y, z));
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL stream out_valid got=%0b exp=%0b cycle=%0d", out_valid, exp_v, i);
      end
      if (exp_v) begin
        seen++;
        checks++;
        if (product !== exp_p) begin
          failures++;
          $display("FAIL stream product got=%h exp=%h", product, exp_p);
        end
      end
    end
    checks++;
    if (seen !== 100) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=100", seen);
    end
  endtask

  task automatic test_divider_inverse();
    logic [N-1:0]   dividend, divisor, quot, rem;
    logic [2*N-1:0] gold;
    for (int i = 0; i < 60 + LAT + 2; i++) begin
      dividend = $urandom();
      divisor  = (i % 3 == 0) ? N'($urandom_range(1, 255)) : $urandom();
      if (divisor == '0) begin
        divisor = 32'd1;
      end
      quot = dividend / divisor;
      rem  = dividend % divisor;
      gold = {{N{1'b0}}, dividend};
      drive_cycle(1'b1, 1'b1, (i < 60), quot, divisor, rem, gold);
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL div_inverse out_valid got=%0b exp=%0b cycle=%0d", out_valid, exp_v, i);
      end
      if (exp_v) begin
        checks++;
        if (product !== exp_p) begin
          failures++;
          $display("FAIL div_inverse product got=%h exp_dividend=%h", product, exp_p);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [N-1:0] x, y, z;
    logic         e, iv;
    for (int i = 0; i < 200 + 2 * LAT; i++) begin
      x  = $urandom(); y = $urandom(); z = $urandom();
      e  = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      iv = (i < 200) ? ($urandom_range(0, 9) < 7) : 1'b0;
      drive_cycle(1'b1, e, iv, x, y, z, golden(x, y, z));
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL stall out_valid got=%0b exp=%0b cycle=%0d en=%0b", out_valid, exp_v, i, e);
      end
      if (exp_v || exp_known) begin
        checks++;
        if (product !== exp_p) begin
          failures++;
          $display("FAIL stall product got=%h exp=%h cycle=%0d", product, exp_p, i);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0] x, y, z;
    for (int i = 0; i < LAT + 8; i++) begin
      x = $urandom(); y = $urandom(); z = $urandom();
      drive_cycle(1'b1, 1'b1, 1'b1, x, y, z, golden(x, y, z));
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre out_valid got=%0b exp=1", out_valid);
    end
    // Asynchronous assertion between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (out_valid !== 1'b0 || product !== '0) begin
      failures++;
      $display("FAIL midreset_async out_valid=%0b product=%h required out_valid=0 product=0",
               out_valid, product);
    end
    for (int i = 0; i < 3; i++) begin
      x = $urandom(); y = $urandom(); z = $urandom();
      drive_cycle(1'b0, 1'b1, 1'b1, x, y, z, golden(x, y, z));
    end
    for (int i = 0; i < LAT + 8; i++) begin
      x = $urandom(); y = $urandom(); z = $urandom();
      drive_cycle(1'b1, 1'b1, (i >= 2 && i < 7), x, y, z, golden(x, y, z));
      checks++;
      if (out_valid !== exp_v) begin
        failures++;
        $display("FAIL midreset_after out_valid got=%0b exp=%0b cycle=%0d", out_valid, exp_v, i);
      end
      if (exp_v) begin
        checks++;
        if (product !== exp_p) begin
          failures++;
          $display("FAIL midreset_after product got=%h exp=%h", product, exp_p);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    c        = '0;
    model_clear();
    test_reset();
    test_basic();
    test_back_to_back();
    test_divider_inverse();
    test_stall();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mul_add
